step_pulse_gen: RTL

//  Step/dir pulse generator for the tuner stepper-motor driver (ШД). Consumer of the

---
 rtl/step_pulse_if.sv | 24 ++
 rtl/step_pulse_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/step_pulse_if.sv
// Handshake bundle between the mode FSM and the step/dir pulse generator.
interface step_pulse_if #(
  parameter int unsigned WIDTH = 16
);
  logic               enable;
  logic               dir_in;
  logic [WIDTH-1:0]   period;
  logic [WIDTH-1:0]   pulse_width;
  logic               clr_count;
  logic               step;
  logic               dir;
  logic               busy;
  logic [2*WIDTH-1:0] count_N;

  modport master (
    output enable, dir_in, period, pulse_width, clr_count,
    input  step, dir, busy, count_N
  );

  modport slave (
    input  enable, dir_in, period, pulse_width, clr_count,
    output step, dir, busy, count_N
  );
endinterface

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse generator: programmable high/low phases, DIR setup before each
// step after a direction change, saturating pulse counter.
module step_pulse_gen #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIR_SETUP = 8
) (
  input logic        clk,
  input logic        rst,
  step_pulse_if.slave bus
);
  localparam int unsigned CW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SETUP_LOAD = WIDTH'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pl_q;
  logic             setup_abort;
  logic             step_q;
  logic             dir_q;
  logic             busy_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] ph_c;
  logic [WIDTH-1:0] pl_c;
  logic             dir_match_c;
  logic             enter_high_c;

  // Phase lengths from the live timing words; only captured on HIGH entry.
  always_comb begin
    ph_c         = (bus.pulse_width == '0) ? WIDTH'(1) : bus.pulse_width;
    pl_c         = (bus.period > ph_c) ? (bus.period - ph_c) : WIDTH'(1);
    dir_match_c  = (bus.dir_in == dir_q);
    enter_high_c = 1'b0;
    case (state)
      IDLE:    enter_high_c = bus.enable && dir_match_c;
      SETUP:   enter_high_c = (cnt == '0) && !setup_abort && bus.enable;
      LOW:     enter_high_c = (cnt == '0) && bus.enable && dir_match_c;
      default: enter_high_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pl_q        <= '0;
      setup_abort <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (enter_high_c) begin
      state  <= HIGH;
      cnt    <= ph_c - WIDTH'(1);
      pl_q   <= pl_c;
      step_q <= 1'b1;
      busy_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state       <= SETUP;
            cnt         <= SETUP_LOAD;
            setup_abort <= 1'b0;
            dir_q       <= bus.dir_in;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          // A drop of enable anywhere in SETUP cancels the pending step.
          if (!bus.enable) setup_abort <= 1'b1;
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state  <= LOW;
            cnt    <= pl_q - WIDTH'(1);
            step_q <= 1'b0;
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
        LOW: begin
          if (cnt == '0) begin
            if (bus.enable) begin
              state       <= SETUP;
              cnt         <= SETUP_LOAD;
              setup_abort <= 1'b0;
              dir_q       <= bus.dir_in;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          step_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Pulse counter: counts step rises, saturates, clear still keeps a same-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.clr_count) begin
      count_q <= enter_high_c ? CW'(1) : '0;
    end else if (enter_high_c && (count_q != '1)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
  assign bus.busy    = busy_q;
  assign bus.count_N = count_q;
endmodule
